// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: R-type funct codes,
// HI/LO op encodings, controller states and small helpers.
package muldiv_ctrl_pkg;

  typedef enum logic [5:0] {
    FN_MFHI  = 6'h10,
    FN_MTHI  = 6'h11,
    FN_MFLO  = 6'h12,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1A,
    FN_DIVU  = 6'h1B
  } funct_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  localparam int DIV_STEPS = 32;

  // Decode-side mapping; only meaningful when the funct is a HI/LO writer.
  function automatic muldiv_op_t funct_to_mdop(input funct_t f);
    case (f)
      FN_MULTU: return MD_MULTU;
      FN_DIV:   return MD_DIV;
      FN_DIVU:  return MD_DIVU;
      FN_MTHI:  return MD_MTHI;
      FN_MTLO:  return MD_MTLO;
      default:  return MD_MULT;
    endcase
  endfunction

  function automatic logic [31:0] neg_if(input logic s, input logic [31:0] v);
    return s ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// 32-step restoring radix-2 divider: magnitude datapath, step counter and
// final sign fixup of quotient/remainder.
module div_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_step,
  output logic        o_last,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [4:0]  r_cnt;
  logic        r_q_neg;
  logic        r_r_neg;

  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;

  // Partial remainder and quotient share one shift; the difference always fits
  // in 32 bits when it is taken, so the top bit only feeds the compare.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_diff     = w_shift[31:0] - r_div;
  assign w_rem_next = w_ge ? w_diff : w_shift[31:0];
  assign w_quo_next = {r_quo[30:0], w_ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (i_start) begin
      r_rem   <= '0;
      r_quo   <= neg_if(i_signed & i_a[31], i_a);
      r_div   <= neg_if(i_signed & i_b[31], i_b);
      r_cnt   <= '0;
      r_q_neg <= i_signed & (i_a[31] ^ i_b[31]);
      r_r_neg <= i_signed & i_a[31];
    end else if (i_step) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign o_last = (r_cnt == 5'(DIV_STEPS - 1));
  assign o_quo  = neg_if(r_q_neg, w_quo_next);
  assign o_rem  = neg_if(r_r_neg, w_rem_next);

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer: pipelined multiply, iterative divide, MTHI/MTLO,
// busy/done reporting and flush cancellation.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  muldiv_op_t  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata
);

  localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

  md_state_t   r_state;
  md_state_t   w_state_next;
  logic [2:0]  r_mul_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic        r_mul_signed;
  logic        r_done;

  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_mul_wr;
  logic        w_div_wr;
  logic        w_div_last;
  logic [31:0] w_div_quo;
  logic [31:0] w_div_rem;
  logic [63:0] w_mul_a_ext;
  logic [63:0] w_mul_b_ext;
  logic [63:0] w_prod;
  logic [63:0] w_mul_result;

  assign w_accept = req_valid & (r_state == ST_IDLE) & ~flush;
  assign w_is_mul = (req_op == MD_MULT) | (req_op == MD_MULTU);
  assign w_is_div = (req_op == MD_DIV) | (req_op == MD_DIVU);

  always_comb begin
    w_state_next = r_state;
    w_mul_wr     = 1'b0;
    w_div_wr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul)      w_state_next = ST_MUL;
        else if (w_accept && w_is_div) w_state_next = ST_DIV;
      end
      ST_MUL: begin
        if (r_mul_cnt == MUL_LAST) begin
          w_state_next = ST_IDLE;
          w_mul_wr     = 1'b1;
        end
      end
      ST_DIV: begin
        if (w_div_last) begin
          w_state_next = ST_IDLE;
          w_div_wr     = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // A squash on the final edge must also suppress the HI/LO write.
    if (flush) begin
      w_state_next = ST_IDLE;
      w_mul_wr     = 1'b0;
      w_div_wr     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_mul_cnt <= '0;
    else if (r_state == ST_MUL && w_state_next == ST_MUL)
      r_mul_cnt <= r_mul_cnt + 3'd1;
    else
      r_mul_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_signed <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_mul_a      <= req_a;
      r_mul_b      <= req_b;
      r_mul_signed <= (req_op == MD_MULT);
    end
  end

  // Low 64 bits of a product of sign/zero-extended operands is the exact result.
  assign w_mul_a_ext = {{32{r_mul_signed & r_mul_a[31]}}, r_mul_a};
  assign w_mul_b_ext = {{32{r_mul_signed & r_mul_b[31]}}, r_mul_b};
  assign w_prod      = w_mul_a_ext * w_mul_b_ext;

  generate
    if (MUL_LAT == 1) begin : g_no_pipe
      assign w_mul_result = w_prod;
    end else begin : g_pipe
      logic [63:0] r_pipe [MUL_LAT-1];
      always_ff @(posedge clk) begin
        r_pipe[0] <= w_prod;
        for (int i = 1; i < MUL_LAT - 1; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_mul_result = r_pipe[MUL_LAT-2];
    end
  endgenerate

  div_iter u_div_iter (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept & w_is_div),
    .i_signed (req_op == MD_DIV),
    .i_a      (req_a),
    .i_b      (req_b),
    .i_step   ((r_state == ST_DIV) & ~flush),
    .o_last   (w_div_last),
    .o_quo    (w_div_quo),
    .o_rem    (w_div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_mul_wr) begin
      r_hi <= w_mul_result[63:32];
      r_lo <= w_mul_result[31:0];
    end else if (w_div_wr) begin
      r_hi <= w_div_rem;
      r_lo <= w_div_quo;
    end else if (w_accept && req_op == MD_MTHI) begin
      r_hi <= req_a;
    end else if (w_accept && req_op == MD_MTLO) begin
      r_lo <= req_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_mul_wr | w_div_wr;
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign hi_rdata  = r_hi;
  assign lo_rdata  = r_lo;

endmodule
